// File: rtl/ghash_ctrl_sequencer.sv
// ghash_ctrl_sequencer
//   Control sequencer for a GHASH datapath. A job of n blocks is started with
//   i_start; the datapath then delivers beats of BLOCK_PROC_PAR blocks on
//   i_valid. After the final beat is accepted, a free-running drain counter
//   produces the hold window and the single-cycle done pulse.
//
//   Optional feature: define GHASH_CTRL_SEQUENCER_ABORT_EN to add i_abort,
//   which returns a busy sequencer to IDLE on the next cycle without a done
//   pulse.
//
// Ports
//   i_clock                 clock
//   i_reset_n               asynchronous active-low reset
//   i_start                 start a job (ignored when n == 0 or when busy)
//   i_valid                 beat of BLOCK_PROC_PAR blocks presented
//   i_skip_bus              current beat flagged skip
//   i_abort                 abort the current job (ABORT_EN builds only)
//   i_rf_static_n_messages  job length in blocks
//   o_busy                  sequencer not idle
//   o_last_cycle            next accepted beat is the final beat
//   o_hold_msg              hold window active
//   o_hash_done             single-cycle completion pulse
//   o_skip_msg              sticky skip flag
//   o_msg_bubbles           padding blocks in the final beat
//   o_msg_count             blocks consumed so far
module ghash_ctrl_sequencer #(
  parameter int NB_N_MESSAGES       = 10,
  parameter int LOG2_BLOCK_PROC_PAR = 2,
  parameter int HOLD_MSG_DELAY      = 4,
  parameter int HASH_DONE_DELAY     = 10
) (
  input  logic                           i_clock,
  input  logic                           i_reset_n,
  input  logic                           i_start,
  input  logic                           i_valid,
  input  logic                           i_skip_bus,
`ifdef GHASH_CTRL_SEQUENCER_ABORT_EN
  input  logic                           i_abort,
`endif
  input  logic [NB_N_MESSAGES:0]         i_rf_static_n_messages,
  output logic                           o_busy,
  output logic                           o_last_cycle,
  output logic                           o_hold_msg,
  output logic                           o_hash_done,
  output logic                           o_skip_msg,
  output logic [LOG2_BLOCK_PROC_PAR-1:0] o_msg_bubbles,
  output logic [NB_N_MESSAGES:0]         o_msg_count
);

  localparam int NW  = NB_N_MESSAGES + 1;
  localparam int LB  = LOG2_BLOCK_PROC_PAR;
  localparam int BPP = 1 << LB;
  localparam int DW  = $clog2(HASH_DONE_DELAY + 1);

  localparam logic [DW-1:0] HOLD_C = DW'(HOLD_MSG_DELAY);
  localparam logic [DW-1:0] DONE_C = DW'(HASH_DONE_DELAY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  state_e          state_q;
  logic [NW-1:0]   n_q;
  logic [NW-1:0]   total_m1_q;   // total_beats - 1
  logic [NW-1:0]   beat_cnt_q;
  logic [NW-1:0]   msg_count_q;
  logic [LB-1:0]   bubbles_q;
  logic [DW-1:0]   drain_cnt_q;
  logic            busy_q;
  logic            last_cycle_q;
  logic            hold_q;
  logic            done_q;
  logic            skip_q;

  // Job-setup arithmetic from the requested length. One extra bit keeps the
  // round-up addition and the bubble subtraction free of carry loss.
  logic [NW:0]     round_up;
  logic [NW-1:0]   total_m1_d;
  logic [LB:0]     bubbles_wide;
  logic [LB-1:0]   bubbles_d;
  logic            n_nonzero;

  // Per-beat and per-drain-cycle increments.
  logic [NW:0]     msg_sum;
  logic [NW-1:0]   msg_count_d;
  logic [NW-1:0]   beat_cnt_d;
  logic [DW-1:0]   drain_cnt_d;

  always_comb begin
    round_up     = {1'b0, i_rf_static_n_messages} + (NW + 1)'(BPP - 1);
    total_m1_d   = NW'(round_up >> LB) - NW'(1);
    bubbles_wide = (LB + 1)'(BPP) - {1'b0, i_rf_static_n_messages[LB-1:0]};
    bubbles_d    = LB'(bubbles_wide);
    n_nonzero    = |i_rf_static_n_messages;

    msg_sum      = {1'b0, msg_count_q} + (NW + 1)'(BPP);
    msg_count_d  = (msg_sum >= {1'b0, n_q}) ? n_q : NW'(msg_sum);
    beat_cnt_d   = beat_cnt_q + NW'(1);
    drain_cnt_d  = drain_cnt_q + DW'(1);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      total_m1_q   <= '0;
      beat_cnt_q   <= '0;
      msg_count_q  <= '0;
      bubbles_q    <= '0;
      drain_cnt_q  <= '0;
      busy_q       <= 1'b0;
      last_cycle_q <= 1'b0;
      hold_q       <= 1'b0;
      done_q       <= 1'b0;
      skip_q       <= 1'b0;
    end else begin
`ifdef GHASH_CTRL_SEQUENCER_ABORT_EN
      // Abort wins over any beat or drain activity; the skip flag survives.
      if (i_abort && (state_q != ST_IDLE)) begin
        state_q      <= ST_IDLE;
        busy_q       <= 1'b0;
        last_cycle_q <= 1'b0;
        hold_q       <= 1'b0;
        done_q       <= 1'b0;
        drain_cnt_q  <= '0;
      end else
`endif
      begin
        case (state_q)
          ST_IDLE: begin
            if (i_start && n_nonzero) begin
              state_q      <= ST_RUN;
              busy_q       <= 1'b1;
              n_q          <= i_rf_static_n_messages;
              total_m1_q   <= total_m1_d;
              bubbles_q    <= bubbles_d;
              beat_cnt_q   <= '0;
              msg_count_q  <= '0;
              skip_q       <= 1'b0;
              // A single-beat job is already on its final beat.
              last_cycle_q <= (total_m1_d == '0);
            end
          end

          ST_RUN: begin
            if (i_valid) begin
              beat_cnt_q  <= beat_cnt_d;
              msg_count_q <= msg_count_d;
              if (i_skip_bus) begin
                skip_q <= 1'b1;
              end
              if (last_cycle_q) begin
                // drain_cnt counts cycles since the final beat was accepted.
                state_q      <= ST_DRAIN;
                last_cycle_q <= 1'b0;
                drain_cnt_q  <= DW'(1);
                hold_q       <= 1'b1;
              end else begin
                last_cycle_q <= (beat_cnt_d == total_m1_q);
              end
            end
          end

          ST_DRAIN: begin
            // Checked before incrementing so drain_cnt never needs to hold
            // HASH_DONE_DELAY+1.
            if (drain_cnt_q == DONE_C) begin
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
              done_q      <= 1'b0;
              hold_q      <= 1'b0;
              drain_cnt_q <= '0;
            end else begin
              drain_cnt_q <= drain_cnt_d;
              hold_q      <= (drain_cnt_d <= HOLD_C);
              done_q      <= (drain_cnt_d == DONE_C);
            end
          end

          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_busy        = busy_q;
  assign o_last_cycle  = last_cycle_q;
  assign o_hold_msg    = hold_q;
  assign o_hash_done   = done_q;
  assign o_skip_msg    = skip_q;
  assign o_msg_bubbles = bubbles_q;
  assign o_msg_count   = msg_count_q;

endmodule
